// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared state codes and level time-limit helper for the rally game sequencer
package game_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      S_IDLE  = 3'd0,
      S_PLAY  = 3'd1,
      S_PAUSE = 3'd2,
      S_WIN   = 3'd3,
      S_LOSE  = 3'd4
   } state_t;

   // Saturating subtraction first, then the floor, so deep levels never wrap.
   function automatic int lvl_time(int enc, int base, int step, int min_t);
      int drop;
      int t;
      drop = (enc - 1) * step;
      t    = (drop >= base) ? 0 : base - drop;
      return (t < min_t) ? min_t : t;
   endfunction

endpackage

// File: rtl/game_level_ctrl_if.sv
// rtl/game_level_ctrl_if.sv - control and status bundle between the game sequencer and its users
interface game_level_ctrl_if #(
   parameter int NUM_LEVELS = 3,
   parameter int TIME_W     = 8
);
   localparam int LVL_W = $clog2(NUM_LEVELS + 1);

   logic [NUM_LEVELS-1:0] level_sw;
   logic                  pause_sw;
   logic                  tick_1hz;
   logic                  all_flags;
   logic                  crash;
   logic                  game_active;
   logic [LVL_W-1:0]      level_id;
   logic [2:0]            state_out;
   logic [TIME_W-1:0]     time_left;
   logic [2:0]            lives_left;
   logic                  win_pulse;
   logic                  lose_pulse;

   modport master (
      output level_sw, pause_sw, tick_1hz, all_flags, crash,
      input  game_active, level_id, state_out, time_left, lives_left, win_pulse, lose_pulse
   );

   modport slave (
      input  level_sw, pause_sw, tick_1hz, all_flags, crash,
      output game_active, level_id, state_out, time_left, lives_left, win_pulse, lose_pulse
   );
endinterface

// File: rtl/game_countdown.sv
// rtl/game_countdown.sv - loadable per-second down-counter that saturates at zero
module game_countdown #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   input  logic         tick,
   output logic [W-1:0] count,
   output logic         expire
);

   // Flags the tick that takes the count to (or holds it at) zero.
   assign expire = en && tick && (count <= W'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en && tick && (count != '0)) begin
         count <= count - W'(1);
      end
   end

endmodule

// File: rtl/game_level_ctrl.sv
// rtl/game_level_ctrl.sv - rally game sequencer: level latch, run FSM, lives counter and win/lose pulses
module game_level_ctrl
   import game_pkg::*;
#(
   parameter int NUM_LEVELS = 3,
   parameter int TIME_W     = 8,
   parameter int TIME_BASE  = 90,
   parameter int TIME_STEP  = 15,
   parameter int MIN_TIME   = 20,
   parameter int LIVES      = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   game_level_ctrl_if.slave   gif
);

   localparam int LVL_W = $clog2(NUM_LEVELS + 1);

   state_t              state;
   logic [LVL_W-1:0]    enc;
   logic                sw_none;
   logic                load;
   logic                expire;
   logic [2:0]          lives;
   logic [TIME_W-1:0]   load_val;

   // Scan from the top down so the lowest set switch is the last writer.
   always_comb begin
      enc = '0;
      for (int i = NUM_LEVELS - 1; i >= 0; i--) begin
         if (gif.level_sw[i]) enc = LVL_W'(i + 1);
      end
   end

   assign sw_none  = (gif.level_sw == '0);
   assign load     = (state == S_IDLE) && (enc != '0);
   assign load_val = TIME_W'(lvl_time(int'(enc), TIME_BASE, TIME_STEP, MIN_TIME));

   game_countdown #(.W(TIME_W)) u_countdown (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .load_val (load_val),
      .en       (state == S_PLAY),
      .tick     (gif.tick_1hz),
      .count    (gif.time_left),
      .expire   (expire)
   );

   assign gif.game_active = (state == S_PLAY);
   assign gif.state_out   = state;
   assign gif.lives_left  = lives;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= S_IDLE;
         gif.level_id   <= '0;
         lives          <= 3'(LIVES);
         gif.win_pulse  <= 1'b0;
         gif.lose_pulse <= 1'b0;
      end else begin
         gif.win_pulse  <= 1'b0;
         gif.lose_pulse <= 1'b0;
         case (state)
            S_IDLE: begin
               if (enc != '0) begin
                  state        <= S_PLAY;
                  gif.level_id <= enc;
                  lives        <= 3'(LIVES);
               end
            end
            S_PLAY: begin
               if (gif.crash && (lives != 3'd0)) lives <= lives - 3'd1;
               if (sw_none) begin
                  state        <= S_IDLE;
                  gif.level_id <= '0;
               end else if (gif.all_flags) begin
                  state         <= S_WIN;
                  gif.win_pulse <= 1'b1;
               end else if (expire || (gif.crash && (lives == 3'd1))) begin
                  state          <= S_LOSE;
                  gif.lose_pulse <= 1'b1;
               end else if (gif.pause_sw) begin
                  state <= S_PAUSE;
               end
            end
            S_PAUSE: begin
               if (sw_none) begin
                  state        <= S_IDLE;
                  gif.level_id <= '0;
               end else if (!gif.pause_sw) begin
                  state <= S_PLAY;
               end
            end
            S_WIN, S_LOSE: begin
               if (sw_none) begin
                  state        <= S_IDLE;
                  gif.level_id <= '0;
               end
            end
            default: begin
               state        <= S_IDLE;
               gif.level_id <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_game_level_ctrl.sv
// tb/tb_game_level_ctrl.sv - self-checking bench: vector table, corner sequences and random run against a model
module tb_game_level_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   game_level_ctrl_if #(.NUM_LEVELS(3), .TIME_W(8)) gif3 ();
   game_level_ctrl_if #(.NUM_LEVELS(8), .TIME_W(8)) gif8 ();

   game_level_ctrl #(.NUM_LEVELS(3), .TIME_W(8), .TIME_BASE(90), .TIME_STEP(15),
                     .MIN_TIME(20), .LIVES(3))
      dut3 (.clk(clk), .rst_n(rst_n), .gif(gif3));

   game_level_ctrl #(.NUM_LEVELS(8), .TIME_W(8), .TIME_BASE(90), .TIME_STEP(15),
                     .MIN_TIME(20), .LIVES(3))
      dut8 (.clk(clk), .rst_n(rst_n), .gif(gif8));

   typedef struct {
      logic [2:0] sw;
      logic       pause, tick, flags, crash;
      int         st, lvl, tm, lv;
      logic       w, l;
   } vec_t;

   vec_t tbl [13];

   // Reference model state: codes 0 idle, 1 play, 2 pause, 3 win, 4 lose
   int m_st, m_lvl, m_tm, m_lv;
   bit m_w, m_l;

   function automatic int limit_for(int level);
      int t;
      t = 90 - (level - 1) * 15;
      if (t < 0) t = 0;
      return (t < 20) ? 20 : t;
   endfunction

   function automatic void m_reset();
      m_st = 0; m_lvl = 0; m_tm = 0; m_lv = 3; m_w = 0; m_l = 0;
   endfunction

   function automatic void m_edge(logic [2:0] sw, bit pause, bit tick, bit flags, bit crash);
      int  level;
      bit  out_of_time, out_of_lives;
      level = 0;
      for (int i = 0; i < 3; i++) if (sw[i] && level == 0) level = i + 1;
      m_w = 0; m_l = 0;
      if (m_st == 0) begin
         if (level != 0) begin m_st = 1; m_lvl = level; m_lv = 3; m_tm = limit_for(level); end
      end else if (m_st == 1) begin
         out_of_time  = tick && (m_tm <= 1);
         out_of_lives = crash && (m_lv == 1);
         if (tick && m_tm > 0) m_tm--;
         if (crash && m_lv > 0) m_lv--;
         if (sw == 0)                          begin m_st = 0; m_lvl = 0; end
         else if (flags)                       begin m_st = 3; m_w = 1; end
         else if (out_of_time || out_of_lives) begin m_st = 4; m_l = 1; end
         else if (pause)                       m_st = 2;
      end else if (m_st == 2) begin
         if (sw == 0)     begin m_st = 0; m_lvl = 0; end
         else if (!pause) m_st = 1;
      end else begin
         if (sw == 0) begin m_st = 0; m_lvl = 0; end
      end
   endfunction

   task automatic chk(string name, int act, int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_all(string tag, int st, int lvl, int tm, int lv, int w, int l);
      chk({tag, " state"},  int'(gif3.state_out),   st);
      chk({tag, " level"},  int'(gif3.level_id),    lvl);
      chk({tag, " time"},   int'(gif3.time_left),   tm);
      chk({tag, " lives"},  int'(gif3.lives_left),  lv);
      chk({tag, " win"},    int'(gif3.win_pulse),   w);
      chk({tag, " lose"},   int'(gif3.lose_pulse),  l);
      chk({tag, " active"}, int'(gif3.game_active), (st == 1) ? 1 : 0);
   endtask

   task automatic drive(logic [2:0] sw, logic pause, logic tick, logic flags, logic crash);
      gif3.level_sw  = sw;
      gif3.pause_sw  = pause;
      gif3.tick_1hz  = tick;
      gif3.all_flags = flags;
      gif3.crash     = crash;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) step();
      rst_n = 1'b1;
   endtask

   initial begin
      tbl[0]  = '{3'b110, 0, 0, 0, 0, 1, 2, 75, 3, 0, 0};
      tbl[1]  = '{3'b110, 0, 1, 0, 0, 1, 2, 74, 3, 0, 0};
      tbl[2]  = '{3'b110, 0, 0, 0, 1, 1, 2, 74, 2, 0, 0};
      tbl[3]  = '{3'b110, 1, 0, 0, 0, 2, 2, 74, 2, 0, 0};
      tbl[4]  = '{3'b110, 1, 1, 0, 1, 2, 2, 74, 2, 0, 0};
      tbl[5]  = '{3'b110, 0, 0, 0, 0, 1, 2, 74, 2, 0, 0};
      tbl[6]  = '{3'b010, 0, 0, 1, 0, 3, 2, 74, 2, 1, 0};
      tbl[7]  = '{3'b010, 0, 0, 0, 0, 3, 2, 74, 2, 0, 0};
      tbl[8]  = '{3'b000, 0, 0, 0, 0, 0, 0, 74, 2, 0, 0};
      tbl[9]  = '{3'b001, 0, 0, 0, 0, 1, 1, 90, 3, 0, 0};
      tbl[10] = '{3'b000, 0, 1, 0, 0, 0, 0, 89, 3, 0, 0};
      tbl[11] = '{3'b100, 0, 0, 0, 0, 1, 3, 60, 3, 0, 0};
      tbl[12] = '{3'b000, 0, 0, 0, 0, 0, 0, 60, 3, 0, 0};

      drive(3'b000, 0, 0, 0, 0);
      gif8.level_sw = '0; gif8.pause_sw = 0; gif8.tick_1hz = 0; gif8.all_flags = 0; gif8.crash = 0;
      do_reset();
      chk_all("reset", 0, 0, 0, 3, 0, 0);

      for (int i = 0; i < 13; i++) begin
         drive(tbl[i].sw, tbl[i].pause, tbl[i].tick, tbl[i].flags, tbl[i].crash);
         step();
         chk_all($sformatf("vec%0d", i), tbl[i].st, tbl[i].lvl, tbl[i].tm, tbl[i].lv,
                 int'(tbl[i].w), int'(tbl[i].l));
      end

      // Level 1 runs out of time on the 90th tick
      drive(3'b001, 0, 0, 0, 0); step();
      drive(3'b001, 0, 1, 0, 0);
      repeat (89) step();
      chk_all("expire_pre", 1, 1, 1, 3, 0, 0);
      step();
      chk_all("expire", 4, 1, 0, 3, 0, 1);
      drive(3'b001, 0, 0, 0, 0); step();
      chk_all("expire_hold", 4, 1, 0, 3, 0, 0);
      drive(3'b000, 0, 0, 0, 0); step();

      // Flags on the final tick: win takes priority
      drive(3'b001, 0, 0, 0, 0); step();
      drive(3'b001, 0, 1, 0, 0);
      repeat (89) step();
      drive(3'b001, 0, 1, 1, 0); step();
      chk_all("win_last_tick", 3, 1, 0, 3, 1, 0);
      drive(3'b000, 0, 0, 0, 0); step();

      // Pause freezes the timer across ten ticks
      drive(3'b001, 0, 0, 0, 0); step();
      drive(3'b001, 0, 1, 0, 0); step();
      drive(3'b001, 1, 0, 0, 0); step();
      chk_all("pause_enter", 2, 1, 89, 3, 0, 0);
      drive(3'b001, 1, 1, 0, 0);
      repeat (10) step();
      chk_all("pause_ticks", 2, 1, 89, 3, 0, 0);
      drive(3'b001, 0, 0, 0, 0); step();
      chk_all("pause_release", 1, 1, 89, 3, 0, 0);
      drive(3'b001, 0, 1, 0, 0); step();
      chk_all("resume_tick", 1, 1, 88, 3, 0, 0);
      drive(3'b000, 0, 0, 0, 0); step();

      // Three crashes lose the run; reselect restores lives
      drive(3'b001, 0, 0, 0, 0); step();
      drive(3'b001, 0, 0, 0, 1); step();
      chk_all("crash1", 1, 1, 90, 2, 0, 0);
      step();
      chk_all("crash2", 1, 1, 90, 1, 0, 0);
      step();
      chk_all("crash3", 4, 1, 90, 0, 0, 1);
      drive(3'b000, 0, 0, 0, 0); step();
      chk_all("crash_idle", 0, 0, 90, 0, 0, 0);
      drive(3'b001, 0, 0, 0, 0); step();
      chk_all("reselect", 1, 1, 90, 3, 0, 0);
      drive(3'b000, 0, 0, 0, 0); step();

      // Eight-level instance: deep levels hit the time floor
      gif8.level_sw = 8'b0100_0000; step();
      chk("l8 lvl7 level", int'(gif8.level_id), 7);
      chk("l8 lvl7 time", int'(gif8.time_left), 20);
      gif8.level_sw = 8'b0001_0000; step();
      chk("l8 latched level", int'(gif8.level_id), 7);
      gif8.level_sw = 8'b0000_0000; step();
      gif8.level_sw = 8'b0001_1000; step();
      chk("l8 lvl4 level", int'(gif8.level_id), 4);
      chk("l8 lvl4 time", int'(gif8.time_left), 45);

      // Asynchronous reset while a win pulse is high
      drive(3'b001, 0, 0, 0, 0); step();
      drive(3'b001, 0, 0, 1, 0); step();
      chk("pre_reset win", int'(gif3.win_pulse), 1);
      #2 rst_n = 1'b0;
      #1;
      chk_all("async_reset", 0, 0, 0, 3, 0, 0);
      chk("async_reset l8 level", int'(gif8.level_id), 0);
      drive(3'b000, 0, 0, 0, 0);
      gif8.level_sw = '0;
      step();
      rst_n = 1'b1;

      // Random run against the reference model
      m_reset();
      for (int c = 0; c < 3000; c++) begin
         logic [2:0] sw;
         bit p, t, f, cr;
         sw = ($urandom_range(0, 19) == 0) ? 3'b000 : 3'($urandom_range(1, 7));
         p  = ($urandom_range(0, 99) < 12);
         t  = ($urandom_range(0, 99) < 35);
         f  = ($urandom_range(0, 199) < 3);
         cr = ($urandom_range(0, 99) < 6);
         drive(sw, p, t, f, cr);
         m_edge(sw, p, t, f, cr);
         step();
         chk_all($sformatf("rnd%0d", c), m_st, m_lvl, m_tm, m_lv, int'(m_w), int'(m_l));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
